// File: rtl/wb_drain_buffer.sv
// Posted write buffer between a write-back cache and memory: FIFO-drains evictions and forwards read misses from pending entries.
// Optional build macro WB_COALESCE_EN merges a push into an existing entry with the same address.
module wb_drain_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = 8,
  parameter int DW    = 8,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [AW-1:0] push_addr_i,
  input  logic [DW-1:0] push_data_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o,
  output logic          overflow_o,
  input  logic          rd_req_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_done_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_we_o,
  output logic          mem_re_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ack_i,
  output logic [1:0]    dbg_state_o
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_READ, S_FWD} state_e;

  // Memory handshake: mem_we/mem_re rise from the FSM state and stay high with
  // stable address/data until the cycle mem_ack is sampled; ack without a strobe is ignored.
  state_e        state_q, state_d;
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          rd_done_q, rd_done_d;
  logic [DW-1:0] rd_data_q, rd_data_d;

  logic          full, empty, alloc, pop, merge;
  logic          rd_hit;
  logic [PW-1:0] rd_idx, scan_idx;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Scan oldest to youngest so the last match (nearest tail) wins.
  always_comb begin
    rd_hit   = 1'b0;
    rd_idx   = '0;
    scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_q + PW'(k);
      if (CW'(k) < count_q && addr_q[scan_idx] == rd_addr_i) begin
        rd_hit = 1'b1;
        rd_idx = scan_idx;
      end
    end
  end

`ifdef WB_COALESCE_EN
  logic          pu_hit;
  logic [PW-1:0] pu_idx, pu_scan;

  always_comb begin
    pu_hit  = 1'b0;
    pu_idx  = '0;
    pu_scan = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pu_scan = head_q + PW'(k);
      if (CW'(k) < count_q && addr_q[pu_scan] == push_addr_i) begin
        pu_hit = 1'b1;
        pu_idx = pu_scan;
      end
    end
  end

  // The head entry is on the bus while draining, so it must not change underneath mem_wdata.
  assign merge = push_i && pu_hit && !(state_q == S_DRAIN && pu_idx == head_q);
`else
  assign merge = 1'b0;
`endif

  assign alloc      = push_i && !merge && !full;
  assign overflow_d = push_i && !merge && full;
  assign pop        = (state_q == S_DRAIN) && mem_ack_i;
  assign count_d    = count_q + CW'(alloc) - CW'(pop);

  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_q[tail_q] <= push_addr_i;
      data_q[tail_q] <= push_data_i;
    end
`ifdef WB_COALESCE_EN
    else if (merge) begin
      data_q[pu_idx] <= push_data_i;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    rd_done_d = 1'b0;
    rd_data_d = rd_data_q;
    case (state_q)
      S_IDLE: begin
        // rd_done_q high means the requester is still releasing the last read.
        if (rd_req_i && !rd_done_q && rd_hit)       state_d = S_FWD;
        else if (rd_req_i && !rd_done_q && !full)   state_d = S_READ;
        else if (!empty)                            state_d = S_DRAIN;
      end
      S_FWD: begin
        rd_data_d = data_q[rd_idx];
        rd_done_d = 1'b1;
        state_d   = S_IDLE;
      end
      S_READ: begin
        if (mem_ack_i) begin
          // A matching eviction pushed during the read is newer than memory.
          rd_data_d = rd_hit ? data_q[rd_idx] : mem_rdata_i;
          rd_done_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (mem_ack_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_done_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_done_q  <= rd_done_d;
      rd_data_q  <= rd_data_d;
      if (alloc) tail_q <= tail_q + 1'b1;
      if (pop)   head_q <= head_q + 1'b1;
    end
  end

  always_comb begin
    mem_we_o    = 1'b0;
    mem_re_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (state_q == S_DRAIN) begin
      mem_we_o    = 1'b1;
      mem_addr_o  = addr_q[head_q];
      mem_wdata_o = data_q[head_q];
    end else if (state_q == S_READ) begin
      mem_re_o   = 1'b1;
      mem_addr_o = rd_addr_i;
    end
  end

  assign full_o      = full;
  assign empty_o     = empty;
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;
  assign rd_data_o   = rd_data_q;
  assign rd_done_o   = rd_done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_drain_buffer.sv
// Directed bench for wb_drain_buffer: memory responder with write scoreboard, read forwarding and reset checks.
module tb_wb_drain_buffer;

  localparam int DEPTH = 8;
  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk, rst;
  logic          push;
  logic [AW-1:0] push_addr;
  logic [DW-1:0] push_data;
  logic          full, empty, overflow;
  logic [CW-1:0] count;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we, mem_re;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic             mem_stall;
  int               ack_delay;
  logic [DW-1:0]    rd_value;
  int               wr_count;
  int               re_cycles;

  wb_drain_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .push_i(push), .push_addr_i(push_addr), .push_data_i(push_data),
    .full_o(full), .empty_o(empty), .count_o(count), .overflow_o(overflow),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_done_o(rd_done),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we), .mem_re_o(mem_re),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack), .dbg_state_o(dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Memory responder and write scoreboard; acts on the falling edge.
  int wait_cnt;
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    wait_cnt  = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_re) re_cycles++;
      if (rst || mem_stall || !(mem_we || mem_re)) begin
        wait_cnt = 0;
      end else if (wait_cnt >= ack_delay) begin
        wait_cnt = 0;
        mem_ack  = 1'b1;
        check("we_re_exclusive", {31'd0, mem_we & mem_re}, 32'd0);
        if (mem_we) begin
          wr_count++;
          if (exp_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
          else check("wr_addr_data", {16'd0, mem_addr, mem_wdata}, {16'd0, exp_q.pop_front()});
        end else begin
          mem_rdata = rd_value;
        end
      end else begin
        wait_cnt++;
      end
    end
  end

  // Driver tasks: all called and returning on the falling edge.
  task automatic do_reset();
    rst       = 1'b1;
    push      = 1'b0;
    rd_req    = 1'b0;
    mem_stall = 1'b1;
    ack_delay = 0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    wr_count  = 0;
    re_cycles = 0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    push      = 1'b1;
    push_addr = a;
    push_data = d;
    @(negedge clk);
    push = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 100 && !(empty && !mem_we); i++) @(negedge clk);
    check(tag, {31'd0, empty}, 32'd1);
  endtask

  task automatic wait_rd_done(input string tag);
    for (int i = 0; i < 50 && !rd_done; i++) @(negedge clk);
    check(tag, {31'd0, rd_done}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; push_addr = '0; push_data = '0;
    rd_req = 1'b0; rd_addr = '0; mem_stall = 1'b1; ack_delay = 0;
    rd_value = '0; wr_count = 0; re_cycles = 0;

    // Reset state
    do_reset();
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_rd_done", {31'd0, rd_done}, 32'd0);
    check("rst_strobes", {30'd0, mem_we, mem_re}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);

    // Two evictions drain in FIFO order
    do_push(8'h13, 8'hAA);
    do_push(8'h2B, 8'h55);
    check("t1_count", {28'd0, count}, 32'd2);
    @(negedge clk);
    check("t1_we_held", {31'd0, mem_we}, 32'd1);
    check("t1_head_addr", {24'd0, mem_addr}, 32'h13);
    exp_q.push_back({8'h13, 8'hAA});
    exp_q.push_back({8'h2B, 8'h55});
    mem_stall = 1'b0;
    ack_delay = 2;
    wait_empty("t1_drained");
    check("t1_wr_count", wr_count, 32'd2);
    check("t1_exp_left", exp_q.size(), 32'd0);

    // Fill to full, then one push too many
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      do_push(8'h80 + 8'(i), 8'(i));
      if (i == DEPTH - 2) check("t2_not_full_at7", {31'd0, full}, 32'd0);
    end
    check("t2_full", {31'd0, full}, 32'd1);
    check("t2_no_ovf_yet", {31'd0, overflow}, 32'd0);
    do_push(8'h90, 8'hEE);
    check("t2_overflow", {31'd0, overflow}, 32'd1);
    check("t2_count", {28'd0, count}, 32'd8);
    @(negedge clk);
    check("t2_ovf_pulse", {31'd0, overflow}, 32'd0);

    // Read hit forwards buffered data in 2 clocks, no memory read
    do_reset();
    do_push(8'h40, 8'h77);
    rd_addr = 8'h40;
    rd_req  = 1'b1;
    @(negedge clk);
    check("t3_done_early", {31'd0, rd_done}, 32'd0);
    @(negedge clk);
    check("t3_done", {31'd0, rd_done}, 32'd1);
    check("t3_data", {24'd0, rd_data}, 32'h77);
    rd_req = 1'b0;
    @(negedge clk);
    check("t3_done_pulse", {31'd0, rd_done}, 32'd0);
    check("t3_no_mem_re", re_cycles, 32'd0);
    exp_q.push_back({8'h40, 8'h77});
    mem_stall = 1'b0;
    wait_empty("t3_still_drained");
    check("t3_wr_count", wr_count, 32'd1);

    // Read miss served by memory
    do_reset();
    mem_stall = 1'b0;
    ack_delay = 3;
    rd_value  = 8'h3C;
    rd_addr   = 8'h05;
    rd_req    = 1'b1;
    @(negedge clk);
    check("t4_mem_re", {31'd0, mem_re}, 32'd1);
    check("t4_mem_addr", {24'd0, mem_addr}, 32'h05);
    wait_rd_done("t4_done");
    check("t4_data", {24'd0, rd_data}, 32'h3C);
    check("t4_re_dropped", {31'd0, mem_re}, 32'd0);
    rd_req = 1'b0;
    @(negedge clk);
    check("t4_done_pulse", {31'd0, rd_done}, 32'd0);
    check("t4_re_low", {31'd0, mem_re}, 32'd0);

    // Eviction of the pending read address makes buffered data authoritative
    do_reset();
    rd_addr = 8'h66;
    rd_req  = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_mem_re", {31'd0, mem_re}, 32'd1);
    do_push(8'h66, 8'h99);
    exp_q.push_back({8'h66, 8'h99});
    rd_value  = 8'h11;
    mem_stall = 1'b0;
    wait_rd_done("t5_done");
    check("t5_data", {24'd0, rd_data}, 32'h99);
    rd_req = 1'b0;
    wait_empty("t5_drained");
    check("t5_wr_count", wr_count, 32'd1);

    // Pushes while a read is pending, with and without coalescing
    do_reset();
    rd_addr = 8'h77;
    rd_req  = 1'b1;
    repeat (2) @(negedge clk);
    do_push(8'h10, 8'h01);
    do_push(8'h20, 8'h02);
    do_push(8'h10, 8'h03);
`ifdef WB_COALESCE_EN
    check("t6_count", {28'd0, count}, 32'd2);
    exp_q.push_back({8'h10, 8'h03});
    exp_q.push_back({8'h20, 8'h02});
`else
    check("t6_count", {28'd0, count}, 32'd3);
    exp_q.push_back({8'h10, 8'h01});
    exp_q.push_back({8'h20, 8'h02});
    exp_q.push_back({8'h10, 8'h03});
`endif
    rd_value  = 8'h5A;
    mem_stall = 1'b0;
    wait_rd_done("t6_done");
    check("t6_data", {24'd0, rd_data}, 32'h5A);
    rd_req = 1'b0;
    wait_empty("t6_drained");
    check("t6_exp_left", exp_q.size(), 32'd0);

    // Asynchronous reset while a write strobe is up
    do_reset();
    do_push(8'h33, 8'hC3);
    @(negedge clk);
    check("t7_we_before", {31'd0, mem_we}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t7_we_async", {31'd0, mem_we}, 32'd0);
    check("t7_count", {28'd0, count}, 32'd0);
    check("t7_empty", {31'd0, empty}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    mem_stall = 1'b0;
    repeat (20) @(negedge clk);
    check("t7_no_writes", wr_count, 32'd0);
    check("t7_still_empty", {31'd0, empty}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
